key_onehot_capture: RTL and testbench
=====================================

KEY_ONEHOT_CAPTURE -- requirements
Module: key_onehot_capture

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the stable-sample count required to accept a press or release (10 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter ACTIVE_LOW, default 1, SHALL select raw key polarity (1: pressed = 0 at pin; 0: pressed = 1).
REQ-003 clk  input  1  SHALL be the single system clock; all state on rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 key_in  input  10  SHALL carry raw, asynchronous, bouncing key/switch levels, bit k = digit k.
REQ-006 data  output  10  SHALL present the last accepted key as a one-hot vector (bit k = digit k), feeding the downstream digit encoder.
REQ-007 valid  output  1  SHALL pulse high for exactly one clk cycle when data is updated with a newly accepted key.
REQ-008 multi_err  output  1  SHALL pulse high for one cycle when a debounced press has more than one key down.
REQ-009 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-010 Each key_in bit SHALL pass a 2-flop synchronizer; the second flop output, inverted when ACTIVE_LOW=1, forms pressed vector p.
REQ-011 The FSM SHALL have states IDLE, DEBOUNCE, HOLD, RELEASE; busy = (state != IDLE).
REQ-012 IDLE: on p != 0, snapshot s <= p, cnt <= 0, go DEBOUNCE; otherwise remain.
REQ-013 DEBOUNCE: if p != s, go IDLE with no output activity; else if cnt == DEBOUNCE_CYCLES-1, go HOLD; else cnt <= cnt+1.
REQ-014 On DEBOUNCE->HOLD with s one-hot: data <= s and valid <= 1 for one cycle.
REQ-015 On DEBOUNCE->HOLD with popcount(s) >= 2: multi_err <= 1 for one cycle; data unchanged; valid stays 0.
REQ-016 HOLD: remain while p != 0 (key changes while held are ignored); on p == 0, cnt <= 0, go RELEASE.
REQ-017 RELEASE: if p != 0, go HOLD; else if cnt == DEBOUNCE_CYCLES-1, go IDLE; else cnt <= cnt+1.
REQ-018 Latency: for key_in stable from before edge E0, valid SHALL be high in the cycle following edge E(2+DEBOUNCE_CYCLES).
REQ-019 cnt width SHALL be $clog2(DEBOUNCE_CYCLES); cnt SHALL never wrap (terminal compare precedes increment).
REQ-020 At most one valid per press-release cycle; a held key SHALL never repeat.
REQ-021 data SHALL hold its value between valid pulses, including through release and multi-key events.
REQ-022 valid and multi_err SHALL never be high in the same cycle.
REQ-023 All outputs SHALL be registered; no combinational path from key_in to any output.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, cnt=0, s=0, data=10'h000, valid=0, multi_err=0, busy=0, and synchronizer flops to the not-pressed level.
REQ-025 Reset asserted mid-DEBOUNCE/HOLD/RELEASE SHALL abort without a valid pulse; after rst_n deasserts, a still-held key SHALL be accepted as a fresh press with full REQ-018 latency.

Verification (DEBOUNCE_CYCLES=4, ACTIVE_LOW=0 unless noted)
REQ-026 key_in=10'h008 held 12 cycles -> valid high in the cycle after edge E6 only, data=10'h008, busy high from E2.
REQ-027 key_in=10'h008 2 cycles, 10'h000 1 cycle, then 10'h008 held -> no valid during bounce; exactly one valid, data=10'h008, timed from last stable start.
REQ-028 key_in=10'h003 held -> multi_err one-cycle pulse, valid never high, data keeps prior value (10'h000 after reset).
REQ-029 10'h020 held 20 cycles, released 10 cycles, 10'h020 again -> exactly two valid pulses, data=10'h020; release of 2 cycles between presses -> only one valid.
REQ-030 rst_n driven low at edge E4 of a 10'h001 press -> all outputs 0 immediately, no valid; key held after rst_n high -> valid 6 edges later, data=10'h001.
REQ-031 ACTIVE_LOW=1, key_in=10'h3F7 held -> data=10'h008 with one valid; key_in=10'h3FF -> no activity.

Source files
------------

// File: rtl/key_onehot_capture.sv
// Debounced 10-key capture: synchronizes raw key levels, debounces press and release,
// and publishes a single accepted key as a one-hot vector with a one-cycle valid strobe.
module key_onehot_capture #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] key_in,
   output logic [9:0] data,
   output logic       valid,
   output logic       multi_err,
   output logic       busy,
   output logic [1:0] state_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   // Synchronizer reset level corresponds to "no key pressed" at the pin.
   localparam logic [9:0] IDLE_LVL = ACTIVE_LOW ? 10'h3FF : 10'h000;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HOLD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   logic [9:0]    sync1_q, sync2_q;
   logic [9:0]    pressed;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [9:0]    snap_q, snap_d;
   logic [9:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          merr_q, merr_d;
   logic          busy_q, busy_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= IDLE_LVL;
         sync2_q <= IDLE_LVL;
      end else begin
         sync1_q <= key_in;
         sync2_q <= sync1_q;
      end
   end

   assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         snap_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         merr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         merr_q  <= merr_d;
         busy_q  <= busy_d;
      end
   end

   // Terminal compare is evaluated before the increment, so cnt never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      snap_d  = snap_q;
      data_d  = data_q;
      valid_d = 1'b0;
      merr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pressed != '0) begin
               snap_d  = pressed;
               cnt_d   = '0;
               state_d = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (pressed != snap_q) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HOLD;
               if ($onehot(snap_q)) begin
                  data_d  = snap_q;
                  valid_d = 1'b1;
               end else begin
                  merr_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HOLD: begin
            if (pressed == '0) begin
               cnt_d   = '0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (pressed != '0) begin
               state_d = HOLD;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign multi_err = merr_q;
   assign busy      = busy_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_key_onehot_capture.sv
// Bench for key_onehot_capture: directed scenarios plus random bouncing key traffic,
// checked against a run-length reference model of press/release acceptance.
module tb_key_onehot_capture;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] key = '0;
   logic [9:0] key_al = 10'h3FF;
   logic [9:0] data_m, data_a;
   logic       valid_m, valid_a, merr_m, merr_a, busy_m, busy_a;
   logic [1:0] st_m, st_a;

   key_onehot_capture #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .key_in(key), .data(data_m), .valid(valid_m),
      .multi_err(merr_m), .busy(busy_m), .state_o(st_m));

   key_onehot_capture #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst_n(rst_n), .key_in(key_al), .data(data_a), .valid(valid_a),
      .multi_err(merr_a), .busy(busy_a), .state_o(st_a));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: 0 = armed, 1 = candidate press, 2 = key locked (held/releasing)
   int         mode, n, cand_start, zero_start;
   logic [9:0] cand_val, exp_data;
   logic       exp_valid, exp_merr, exp_busy;
   logic [9:0] pq[$];

   int valid_cnt, merr_cnt, first_valid_edge, first_busy_edge;
   int al_valid_cnt, al_busy_cnt, al_first_valid_edge;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mode = 0; n = 0; cand_start = 0; zero_start = -1; cand_val = '0;
      pq = {10'h000, 10'h000};
      exp_data = '0; exp_valid = 1'b0; exp_merr = 1'b0; exp_busy = 1'b0;
      valid_cnt = 0; merr_cnt = 0; first_valid_edge = -1; first_busy_edge = -1;
      al_valid_cnt = 0; al_busy_cnt = 0; al_first_valid_edge = -1;
   endtask

   // A press is accepted once D+1 consecutive identical non-zero samples start while armed;
   // re-arming needs D+1 consecutive all-zero samples after acceptance.
   task automatic model_edge(input logic [9:0] k);
      logic [9:0] v;
      pq.push_back(k);
      v = pq.pop_front();
      exp_valid = 1'b0;
      exp_merr = 1'b0;
      case (mode)
         0: if (v != 0) begin mode = 1; cand_val = v; cand_start = n; end
         1: begin
            if (v != cand_val) mode = 0;
            else if (n - cand_start == D) begin
               mode = 2; zero_start = -1;
               if ($countones(v) == 1) begin exp_valid = 1'b1; exp_data = v; end
               else exp_merr = 1'b1;
            end
         end
         default: begin
            if (v != 0) zero_start = -1;
            else if (zero_start < 0) zero_start = n;
            else if (n - zero_start == D) mode = 0;
         end
      endcase
      exp_busy = (mode != 0);
   endtask

   task automatic step(input logic [9:0] k);
      int e;
      key = k;
      @(posedge clk);
      e = n;
      model_edge(k);
      n++;
      #1;
      chk("valid", 32'(valid_m), 32'(exp_valid));
      chk("multi_err", 32'(merr_m), 32'(exp_merr));
      chk("busy", 32'(busy_m), 32'(exp_busy));
      chk("data", 32'(data_m), 32'(exp_data));
      chk("excl", 32'(valid_m & merr_m), 32'd0);
      if (valid_m === 1'b1) begin
         valid_cnt++;
         if (first_valid_edge < 0) first_valid_edge = e;
      end
      if (merr_m === 1'b1) merr_cnt++;
      if (busy_m === 1'b1 && first_busy_edge < 0) first_busy_edge = e;
      if (valid_a === 1'b1) begin
         al_valid_cnt++;
         if (al_first_valid_edge < 0) al_first_valid_edge = e;
      end
      if (busy_a === 1'b1 || merr_a === 1'b1) al_busy_cnt++;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_data"}, 32'(data_m), 32'd0);
      chk({tag, "_valid"}, 32'(valid_m), 32'd0);
      chk({tag, "_merr"}, 32'(merr_m), 32'd0);
      chk({tag, "_busy"}, 32'(busy_m), 32'd0);
      chk({tag, "_state"}, 32'(st_m), 32'd0);
      chk({tag, "_al_busy"}, 32'(busy_a), 32'd0);
   endtask

   task automatic reset_now(input string tag);
      rst_n = 1'b0;
      #1;
      check_all_zero(tag);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset_now(tag);
   endtask

   initial begin
      model_reset();

      // Single key, timing of busy and valid
      do_reset("rst0");
      repeat (12) step(10'h008);
      chk("r26_first_busy", 32'(first_busy_edge), 32'd2);
      chk("r26_first_valid", 32'(first_valid_edge), 32'd6);
      chk("r26_valid_cnt", 32'(valid_cnt), 32'd1);
      chk("r26_data", 32'(data_m), 32'h008);

      // Bounce before a stable press
      do_reset("rst1");
      step(10'h008); step(10'h008); step(10'h000);
      repeat (12) step(10'h008);
      chk("r27_first_valid", 32'(first_valid_edge), 32'd9);
      chk("r27_valid_cnt", 32'(valid_cnt), 32'd1);
      chk("r27_data", 32'(data_m), 32'h008);

      // Two keys together
      do_reset("rst2");
      repeat (12) step(10'h003);
      chk("r28_merr_cnt", 32'(merr_cnt), 32'd1);
      chk("r28_valid_cnt", 32'(valid_cnt), 32'd0);
      chk("r28_data", 32'(data_m), 32'h000);

      // Full release between presses vs. short release
      do_reset("rst3");
      repeat (20) step(10'h020);
      repeat (10) step(10'h000);
      repeat (20) step(10'h020);
      chk("r29_two_valid", 32'(valid_cnt), 32'd2);
      chk("r29_data", 32'(data_m), 32'h020);
      do_reset("rst4");
      repeat (12) step(10'h020);
      repeat (2) step(10'h000);
      repeat (12) step(10'h020);
      chk("r29_one_valid", 32'(valid_cnt), 32'd1);

      // Reset in the middle of a debounce
      do_reset("rst5");
      repeat (5) step(10'h001);
      reset_now("r30_abort");
      repeat (12) step(10'h001);
      chk("r30_first_valid", 32'(first_valid_edge), 32'd6);
      chk("r30_valid_cnt", 32'(valid_cnt), 32'd1);
      chk("r30_data", 32'(data_m), 32'h001);

      // Active-low instance
      do_reset("rst6");
      key_al = 10'h3F7;
      repeat (12) step(10'h000);
      chk("r31_al_valid_cnt", 32'(al_valid_cnt), 32'd1);
      chk("r31_al_first_valid", 32'(al_first_valid_edge), 32'd6);
      chk("r31_al_data", 32'(data_a), 32'h008);
      do_reset("rst7");
      key_al = 10'h3FF;
      repeat (12) step(10'h000);
      chk("r31_al_quiet_valid", 32'(al_valid_cnt), 32'd0);
      chk("r31_al_quiet_busy", 32'(al_busy_cnt), 32'd0);

      // Random bouncing traffic
      do_reset("rst8");
      begin
         logic [9:0] cur;
         cur = '0;
         for (int seg = 0; seg < 300; seg++) begin
            int kind, dur;
            kind = $urandom_range(0, 19);
            dur = $urandom_range(1, 12);
            if (kind < 5) cur = '0;
            else if (kind < 11) cur = 10'(1) << $urandom_range(0, 9);
            else if (kind < 14) cur = 10'($urandom_range(1, 1023));
            else if (kind == 19) begin
               do_reset("rnd_rst");
               continue;
            end
            for (int i = 0; i < dur; i++) step(cur);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
